// File: rtl/hs_rx_fifo.sv
// rtl/hs_rx_fifo.sv - first-word fall-through receive FIFO with registered ready/valid
//
// Optional feature macro: HS_RX_XFER_CNT_EN adds the xfer_cnt pop counter output.
//
// Parameters
//   DATA_W    payload width in bits (1..64)
//   DEPTH     number of entries, power of two (2..64)
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    upstream payload
//   in_valid   upstream offers in_data
//   in_ready   FIFO can accept a word this cycle (registered decode)
//   out_data   head entry, zero whenever the FIFO is empty
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   count      number of words held
//   xfer_cnt   (HS_RX_XFER_CNT_EN only) wrapping count of pops

module hs_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     count
`ifdef HS_RX_XFER_CNT_EN
    ,
    output logic [15:0]       xfer_cnt
`endif
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
    logic              pop;

    // Handshake flags come only from count_q, so a pop at the full boundary
    // cannot open in_ready in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Storage is not reset; gating on out_valid keeps out_data at zero while
    // empty, which also hides any stale pre-reset contents.
    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

    // Pointers are exactly PW bits wide, so +1 wraps DEPTH-1 -> 0 naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef HS_RX_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb/tb_hs_rx_fifo.sv - scoreboard testbench for hs_rx_fifo
module tb_hs_rx_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CW-1:0]     count;
`ifdef HS_RX_XFER_CNT_EN
    logic [15:0]       xfer_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    int exp_pops = 0;
    logic [DATA_W-1:0] sb [$];

    hs_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef HS_RX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [DATA_W-1:0] w);
        sb.push_back(w);
        exp_pops++;
    endtask

    // Monitor: every handshake the DUT presents retires the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) begin
                check("unexpected_pop", {16'h0, out_data}, 32'hDEAD_BEEF);
            end else begin
                check("pop_data", {16'h0, out_data}, {16'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] held;

        // Reset state
        cyc();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(out_data), 0);
        rst = 1'b0;

        // Single word, first edge after reset, no same-cycle bypass
        in_data = 16'h1234;
        in_valid = 1'b1;
        #1;
        check("no_bypass_valid", 32'(out_valid), 0);
        check("no_bypass_data", 32'(out_data), 0);
        expect_word(16'h1234);
        cyc();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h1234);
        check("single_count", 32'(count), 1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_data", 32'(out_data), 32'h1234);
            check("hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("drain_count", 32'(count), 0);
        check("drain_data_zero", 32'(out_data), 0);

        // Fill to DEPTH, fifth word held upstream
        for (int i = 0; i < 5; i++) begin
            in_data = 16'hA0 + 16'(i);
            in_valid = 1'b1;
            if (i < 4) expect_word(16'hA0 + 16'(i));
            cyc();
            if (i == 3) begin
                check("full_count", 32'(count), 4);
                check("full_in_ready", 32'(in_ready), 0);
            end
        end
        check("full_hold_count", 32'(count), 4);
        check("full_head", 32'(out_data), 32'hA0);

        // Pop while full: no same-cycle push, A4 enters next cycle
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("pop_full_count", 32'(count), 3);
        check("pop_full_in_ready", 32'(in_ready), 1);
        expect_word(16'hA4);
        cyc();
        in_valid = 1'b0;
        check("refill_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        out_ready = 1'b0;
        check("drain2_count", 32'(count), 0);

        // Streaming: 100 words with simultaneous push and pop
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 16'(i);
            expect_word(16'(i));
            cyc();
            check("stream_count", 32'(count), 1);
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 0);

        // Short mid-cycle reset discards buffered words
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'hB1 + 16'(i);
            cyc();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_ready", 32'(in_ready), 1);
        check("async_rst_data", 32'(out_data), 0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("post_rst_count", 32'(count), 0);
        in_data = 16'hC5;
        in_valid = 1'b1;
        expect_word(16'hC5);
        cyc();
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        check("post_rst_drain", 32'(count), 0);

`ifdef HS_RX_XFER_CNT_EN
        // Pop counter wraps: 65537 pops after reset leaves 1
        #2 rst = 1'b1;
        #2;
        check("xfer_rst", 32'(xfer_cnt), 0);
        rst = 1'b0;
        cyc();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = 16'(i);
            expect_word(16'(i));
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        check("xfer_wrap", 32'(xfer_cnt), 1);
`endif

        cyc();
        check("sb_empty", 32'(sb.size()), 0);
        check("pop_total", 32'(pops), 32'(exp_pops));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
